// File: rtl/fwd_hazard_sb.sv
// fwd_hazard_sb: EX-stage operand forwarding, load-use and long-op scoreboard hazards,
// and a saturating stall-cycle counter for the 5-stage MIPS pipeline.
module fwd_hazard_sb #(
  parameter int REG_W    = 5,
  parameter int NUM_SRC  = 2,
  parameter int LONG_LAT = 4,
  parameter int CNT_W    = 16
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic [NUM_SRC*REG_W-1:0] id_rs_i,
  input  logic [REG_W-1:0]         id_rd_i,
  input  logic                     id_wr_i,
  input  logic                     id_long_i,
  input  logic [NUM_SRC*REG_W-1:0] ex_src_i,
  input  logic                     ex_memrd_i,
  input  logic [REG_W-1:0]         ex_rd_i,
  input  logic [REG_W-1:0]         exm_rd_i,
  input  logic                     exm_wr_i,
  input  logic [REG_W-1:0]         wb_rd_i,
  input  logic                     wb_wr_i,
  output logic [2*NUM_SRC-1:0]     fwd_sel_o,
  output logic                     stall_o,
  output logic                     long_busy_o,
  output logic                     long_done_o,
  output logic [REG_W-1:0]         long_rd_o,
  output logic [CNT_W-1:0]         stall_cnt_o
);
  localparam int LW = $clog2(LONG_LAT + 1);

  logic             pending, lwb_valid, done, load_use, raw, waw, structural, issue;
  logic [LW-1:0]    cnt;
  logic [REG_W-1:0] long_rd, lwb_rd;
  logic [CNT_W-1:0] stall_cnt;

  assign done = pending && cnt == LW'(1);

  always_comb begin
    load_use = 1'b0;
    raw      = 1'b0;
    for (int k = 0; k < NUM_SRC; k++) begin
      load_use |= ex_memrd_i && ex_rd_i != '0 && id_rs_i[k*REG_W +: REG_W] == ex_rd_i;
      raw      |= pending && !done && long_rd != '0 && id_rs_i[k*REG_W +: REG_W] == long_rd;
    end
  end

  // The done cycle releases all long-op stalls so a consumer or a new long op can advance.
  assign waw        = pending && !done && id_wr_i && id_rd_i != '0 && id_rd_i == long_rd;
  assign structural = id_long_i && pending && !done;
  assign stall_o    = load_use || raw || waw || structural;
  assign issue      = id_long_i && !stall_o;

  for (genvar k = 0; k < NUM_SRC; k++) begin : g_fwd
    logic [REG_W-1:0] s;
    assign s = ex_src_i[k*REG_W +: REG_W];
    assign fwd_sel_o[2*k +: 2] = s == '0                        ? 2'b00 :
                                 exm_wr_i && exm_rd_i == s      ? 2'b01 :
                                 wb_wr_i && wb_rd_i == s        ? 2'b10 :
                                 lwb_valid && lwb_rd == s       ? 2'b11 : 2'b00;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      pending   <= 1'b0;
      cnt       <= '0;
      long_rd   <= '0;
      lwb_valid <= 1'b0;
      lwb_rd    <= '0;
      stall_cnt <= '0;
    end else begin
      pending   <= issue || (pending && !done);
      cnt       <= issue ? LW'(LONG_LAT) : pending ? cnt - LW'(1) : cnt;
      long_rd   <= issue ? (id_wr_i ? id_rd_i : '0) : long_rd;
      lwb_valid <= done && long_rd != '0;
      lwb_rd    <= done ? long_rd : lwb_rd;
      stall_cnt <= stall_o && stall_cnt != '1 ? stall_cnt + 1'b1 : stall_cnt;
    end
  end

  assign long_busy_o = pending;
  assign long_done_o = done;
  assign long_rd_o   = long_rd;
  assign stall_cnt_o = stall_cnt;
endmodule

// File: tb/tb_fwd_hazard_sb.sv
// tb_fwd_hazard_sb: directed scenarios checked against a cycle-indexed behavioural model
// plus hand-computed literal expectations.
module tb_fwd_hazard_sb;
  localparam int RW = 5, NS = 2, LL = 4, CW = 3, SAT = 7;

  logic clk = 0, rst = 1;
  logic [NS*RW-1:0] id_rs = '0, ex_src = '0;
  logic [RW-1:0]    id_rd = '0, ex_rd = '0, exm_rd = '0, wb_rd = '0;
  logic             id_wr = 0, id_long = 0, ex_memrd = 0, exm_wr = 0, wb_wr = 0;
  logic [2*NS-1:0]  fwd_sel;
  logic             stall, busy, done;
  logic [RW-1:0]    long_rd;
  logic [CW-1:0]    stall_cnt;

  fwd_hazard_sb #(.REG_W(RW), .NUM_SRC(NS), .LONG_LAT(LL), .CNT_W(CW)) dut (
    .clk_i(clk), .rst_i(rst), .id_rs_i(id_rs), .id_rd_i(id_rd), .id_wr_i(id_wr),
    .id_long_i(id_long), .ex_src_i(ex_src), .ex_memrd_i(ex_memrd), .ex_rd_i(ex_rd),
    .exm_rd_i(exm_rd), .exm_wr_i(exm_wr), .wb_rd_i(wb_rd), .wb_wr_i(wb_wr),
    .fwd_sel_o(fwd_sel), .stall_o(stall), .long_busy_o(busy), .long_done_o(done),
    .long_rd_o(long_rd), .stall_cnt_o(stall_cnt));

  always #5 clk = ~clk;

  int checks = 0, passed = 0;

  task automatic chk(string name, int act, int exp);
    checks++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  // Model: the long op is described by the cycle index at which it completes and the
  // cycle index at which its result is forwardable, rather than by a countdown.
  int cyc = 0, m_done_t = -1, m_lwb_t = -1, m_rd = 0, m_lwb_rd = 0, m_cnt = 0;
  bit m_pend = 0;
  bit e_done, e_lwb, e_stall;
  int e_fwd;

  always_comb begin
    e_done  = m_pend && cyc == m_done_t;
    e_lwb   = cyc == m_lwb_t;
    e_stall = (id_long && m_pend && !e_done) ||
              (m_pend && !e_done && id_wr && id_rd != 0 && int'(id_rd) == m_rd);
    e_fwd   = 0;
    for (int k = 0; k < NS; k++) begin
      int r, s, sel;
      r = int'(id_rs[k*RW +: RW]);
      s = int'(ex_src[k*RW +: RW]);
      if (ex_memrd && ex_rd != 0 && r == int'(ex_rd)) e_stall = 1;
      if (m_pend && !e_done && m_rd != 0 && r == m_rd) e_stall = 1;
      if (s == 0) sel = 0;
      else if (exm_wr && int'(exm_rd) == s) sel = 1;
      else if (wb_wr && int'(wb_rd) == s) sel = 2;
      else if (e_lwb && m_lwb_rd == s) sel = 3;
      else sel = 0;
      e_fwd = e_fwd | (sel << (2*k));
    end
  end

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_pend <= 0; m_done_t <= -1; m_lwb_t <= -1; m_rd <= 0; m_lwb_rd <= 0; m_cnt <= 0;
    end else begin
      cyc <= cyc + 1;
      if (e_done) begin
        m_pend   <= 0;
        m_lwb_rd <= m_rd;
        if (m_rd != 0) m_lwb_t <= cyc + 1;
      end
      if (id_long && !e_stall) begin
        m_pend   <= 1;
        m_done_t <= cyc + LL;
        m_rd     <= id_wr ? int'(id_rd) : 0;
      end
      if (e_stall && m_cnt < SAT) m_cnt <= m_cnt + 1;
    end
  end

  initial forever begin
    @(negedge clk);
    chk("m_fwd", int'(fwd_sel), e_fwd);
    chk("m_stall", int'(stall), int'(e_stall));
    chk("m_busy", int'(busy), int'(m_pend));
    chk("m_done", int'(done), int'(e_done));
    chk("m_long_rd", int'(long_rd), m_rd);
    chk("m_cnt", int'(stall_cnt), m_cnt);
  end

  task automatic nx();
    @(posedge clk); #1;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1 rst = 0;
    @(negedge clk);
    chk("rst_fwd", int'(fwd_sel), 0); chk("rst_stall", int'(stall), 0);
    chk("rst_busy", int'(busy), 0);   chk("rst_done", int'(done), 0);
    chk("rst_rd", int'(long_rd), 0);  chk("rst_cnt", int'(stall_cnt), 0);
    // forwarding priority
    nx(); ex_src = {5'd3, 5'd3}; exm_wr = 1; exm_rd = 3; wb_wr = 1; wb_rd = 3;
    @(negedge clk); chk("fwd_exm", int'(fwd_sel), 4'b0101);
    nx(); exm_wr = 0;
    @(negedge clk); chk("fwd_wb", int'(fwd_sel), 4'b1010);
    nx(); ex_src = '0; exm_wr = 1;
    @(negedge clk); chk("fwd_r0", int'(fwd_sel), 0);
    // load-use
    nx(); exm_wr = 0; wb_wr = 0; exm_rd = 0; wb_rd = 0;
    ex_memrd = 1; ex_rd = 7; id_rs = {5'd2, 5'd7};
    @(negedge clk); chk("lu_stall", int'(stall), 1);
    nx(); ex_memrd = 0; ex_rd = 0;
    @(negedge clk); chk("lu_release", int'(stall), 0); chk("lu_cnt", int'(stall_cnt), 1);
    nx(); ex_memrd = 1; ex_rd = 0;
    @(negedge clk); chk("lu_r0", int'(stall), 0);
    // long op RAW
    nx(); ex_memrd = 0; id_rs = '0; id_long = 1; id_wr = 1; id_rd = 9;
    @(negedge clk); chk("long_issue_ok", int'(stall), 0);
    nx(); id_long = 0; id_wr = 0; id_rd = 0; id_rs = {5'd0, 5'd9};
    @(negedge clk); chk("long_busy", int'(busy), 1); chk("long_rd9", int'(long_rd), 9);
    chk("raw_c0", int'(stall), 1);
    for (int c = 1; c <= 2; c++) begin
      nx();
      @(negedge clk); chk("raw_c12", int'(stall), 1); chk("raw_nodone", int'(done), 0);
    end
    nx();
    @(negedge clk); chk("done_c3", int'(done), 1); chk("done_rd", int'(long_rd), 9);
    chk("done_nostall", int'(stall), 0);
    nx(); id_rs = '0; ex_src = {5'd0, 5'd9};
    @(negedge clk); chk("lwb_fwd", int'(fwd_sel), 4'b0011); chk("c4_idle", int'(busy), 0);
    chk("c4_cnt", int'(stall_cnt), 4);
    nx();
    @(negedge clk); chk("lwb_clear", int'(fwd_sel), 0);
    // WAW and structural
    nx(); ex_src = '0; id_long = 1; id_wr = 1; id_rd = 9;
    @(negedge clk); chk("issue2", int'(stall), 0);
    nx(); id_long = 0; id_wr = 1; id_rd = 9;
    @(negedge clk); chk("waw", int'(stall), 1);
    nx(); id_long = 1; id_wr = 1; id_rd = 5;
    @(negedge clk); chk("struct_c1", int'(stall), 1);
    nx();
    @(negedge clk); chk("struct_c2", int'(stall), 1);
    nx();
    @(negedge clk); chk("b2b_done", int'(done), 1); chk("b2b_nostall", int'(stall), 0);
    nx(); id_long = 0; id_wr = 0; id_rd = 0; ex_src = {5'd0, 5'd9};
    @(negedge clk); chk("b2b_busy", int'(busy), 1); chk("b2b_rd", int'(long_rd), 5);
    chk("b2b_lwb_old", int'(fwd_sel), 4'b0011);
    nx(); ex_src = '0;
    repeat (2) nx();
    @(negedge clk); chk("b2b_done2", int'(done), 1); chk("b2b_done2_rd", int'(long_rd), 5);
    // async reset mid-op
    nx(); id_long = 1; id_wr = 1; id_rd = 9;
    nx(); id_long = 0; id_wr = 0; id_rd = 0; id_rs = {5'd0, 5'd9};
    nx(); nx(); #2;
    chk("pre_rst_stall", int'(stall), 1); chk("pre_rst_busy", int'(busy), 1);
    rst = 1; #1;
    chk("arst_stall", int'(stall), 0); chk("arst_busy", int'(busy), 0);
    chk("arst_rd", int'(long_rd), 0);  chk("arst_cnt", int'(stall_cnt), 0);
    chk("arst_done", int'(done), 0);   chk("arst_fwd", int'(fwd_sel), 0);
    @(posedge clk); #1 rst = 0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk); chk("post_rst_done", int'(done), 0);
      nx();
    end
    // counter saturation
    ex_memrd = 1; ex_rd = 7; id_rs = {5'd0, 5'd7};
    repeat (10) nx();
    @(negedge clk); chk("sat_cnt", int'(stall_cnt), 7); chk("sat_stall", int'(stall), 1);
    nx(); ex_memrd = 0; ex_rd = 0; id_rs = '0;
    @(negedge clk); chk("sat_hold", int'(stall_cnt), 7);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
